// File: rtl/uart_char_tx.sv
// ---------------------------------------------------------------------------
// uart_char_tx
//
// Buffers bytes from the core's simulated UART character port in a small
// FIFO and serializes each one as an 8N1 asynchronous frame on txd.
//
// Ports:
//   clk        in   main clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high
//   char_in    in   [7:0] byte to transmit
//   char_valid in   push strobe, one byte offered per high cycle
//   txd        out  serial line, idles high
//   busy       out  frame in flight or FIFO non-empty
//   fifo_full  out  FIFO holds 2^FIFO_AW bytes
//   fifo_count out  [FIFO_AW:0] bytes buffered, excluding the one shifting
//   overflow   out  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_char_tx #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  output logic               txd,
  output logic               busy,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [FIFO_AW:0]    wptr_q, wptr_d;
  logic [FIFO_AW:0]    rptr_q, rptr_d;

  logic [7:0]          mem [DEPTH];

  logic                fifo_empty;
  logic                full;
  logic                pop;
  logic                push;
  logic                bit_end;

  // Pointers carry one extra wrap bit: equal means empty, equal except for
  // the MSB means full.
  assign fifo_empty = (wptr_q == rptr_q);
  assign full       = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign bit_end    = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q[FIFO_AW-1:0]];
          cnt_d   = CNT_RELOAD;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = CNT_RELOAD;
          idx_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // Next bit is shift_q[1]; drive it alongside the shift so txd
            // stays a plain register.
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_d = mem[rptr_q[FIFO_AW-1:0]];
            cnt_d   = CNT_RELOAD;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A pop in the same cycle frees the slot being written, so a push into
    // a full FIFO is still accepted then.
    push       = char_valid && (!full || pop);
    wptr_d     = wptr_q + (FIFO_AW+1)'(push);
    rptr_d     = rptr_q + (FIFO_AW+1)'(pop);
    overflow_d = overflow_q || (char_valid && full && !pop);
    busy_d     = (state_d != IDLE) || (wptr_d != rptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr_q[FIFO_AW-1:0]] <= char_in;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_full  = full;
  assign fifo_count = wptr_q - rptr_q;

endmodule

// File: tb/tb_uart_char_tx.sv
module tb_uart_char_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int FRAME   = 10 * CLK_DIV;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         char_in;
  logic               char_valid;
  logic               txd;
  logic               busy;
  logic               fifo_full;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;

  uart_char_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .txd        (txd),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted byte gets an accept edge and the edge
  // on which it is popped into the shifter. A frame occupies the FRAME
  // cycles following its pop edge; everything else follows from that.
  typedef struct {
    logic [7:0] data;
    int         acc;
    int         pop;
  } ent_t;

  ent_t q[$];
  int   edge_no   = 0;
  int   last_pop  = -100000;
  logic m_ovf     = 1'b0;
  int   vectors   = 0;
  int   miscompares = 0;

  function automatic int next_pop_edge();
    int np = 2147483647;
    foreach (q[i]) if (q[i].pop > edge_no && q[i].pop < np) np = q[i].pop;
    return np;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    int   e = edge_no;
    int   occ = 0;
    bit   popnow = 0;
    int   p;
    ent_t n;
    if (r) begin
      q.delete();
      last_pop = -100000;
      m_ovf    = 1'b0;
      return;
    end
    foreach (q[i]) begin
      if (q[i].acc < e && q[i].pop >= e) occ++;
      if (q[i].pop == e) popnow = 1;
    end
    if (v) begin
      if (occ < DEPTH || popnow) begin
        p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
        n.data = d; n.acc = e; n.pop = p;
        q.push_back(n);
        last_pop = p;
      end else begin
        m_ovf = 1'b1;
      end
    end
    while (q.size() > 0 && q[0].pop + FRAME < e) void'(q.pop_front());
  endtask

  task automatic check_outputs();
    int   e = edge_no;
    logic exp_txd = 1'b1;
    bit   inframe = 0;
    int   cnt = 0;
    int   k;
    logic exp_busy;
    logic exp_full;
    foreach (q[i]) begin
      if (e >= q[i].pop && e < q[i].pop + FRAME) begin
        inframe = 1;
        k = (e - q[i].pop) / CLK_DIV;
        if (k == 0)      exp_txd = 1'b0;
        else if (k <= 8) exp_txd = q[i].data[k-1];
        else             exp_txd = 1'b1;
      end
      if (q[i].acc <= e && q[i].pop > e) cnt++;
    end
    exp_busy = inframe || (cnt != 0);
    exp_full = (cnt == DEPTH);

    vectors++;
    assert (txd === exp_txd) else begin
      miscompares++;
      $error("FAIL txd edge=%0d got=%b exp=%b", e, txd, exp_txd);
    end
    vectors++;
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("FAIL busy edge=%0d got=%b exp=%b", e, busy, exp_busy);
    end
    vectors++;
    assert (fifo_count === (FIFO_AW+1)'(cnt)) else begin
      miscompares++;
      $error("FAIL fifo_count edge=%0d got=%0d exp=%0d", e, fifo_count, cnt);
    end
    vectors++;
    assert (fifo_full === exp_full) else begin
      miscompares++;
      $error("FAIL fifo_full edge=%0d got=%b exp=%b", e, fifo_full, exp_full);
    end
    vectors++;
    assert (overflow === m_ovf) else begin
      miscompares++;
      $error("FAIL overflow edge=%0d got=%b exp=%b", e, overflow, m_ovf);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst        = r;
    char_valid = v;
    char_in    = d;
    @(posedge clk);
    edge_no++;
    model_edge(r, v, d);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int np;
    int gap;
    rst = 1'b1; char_valid = 1'b0; char_in = 8'h00;

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(3);

    // Single frame 0x55
    step(1'b0, 1'b1, 8'h55);
    idle(FRAME + 8);

    // Two back-to-back frames
    step(1'b0, 1'b1, 8'h41);
    step(1'b0, 1'b1, 8'h0A);
    idle(2 * FRAME + 8);

    // Fill to full: first byte popped, 16 buffered
    for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, 8'(i));
    // Push on the exact STOP->START pop edge while full
    np = next_pop_edge();
    while (edge_no + 1 < np) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hEE);
    // Pushes while full with no pop are dropped
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
    idle(18 * FRAME + 8);

    // Reset mid-frame during data bit 3
    step(1'b0, 1'b1, 8'hC3);
    idle(1 + CLK_DIV * 4 + 1);
    step(1'b1, 1'b0, 8'h00);
    idle(3);
    step(1'b0, 1'b1, 8'hA5);
    idle(FRAME + 8);

    // Paced stream of 40 bytes, FIFO kept shallow; pointers wrap
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
    for (int i = 3; i < 40; i++) begin
      gap = $urandom_range(FRAME - 3, FRAME + 2);
      idle(gap);
      step(1'b0, 1'b1, 8'($urandom));
    end
    idle(4 * FRAME + 8);

    // Random traffic, bursty enough to overflow occasionally
    for (int i = 0; i < 600; i++)
      step(1'b0, ($urandom_range(0, 7) == 0), 8'($urandom));
    idle(18 * FRAME + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
